// File: rtl/mem_bus_responder.sv
// Memory-bus responder: serves tester read/write requests from an internal word array with a fixed read latency.
// Define MEM_RESP_STALL_EN to add LFSR-driven pseudo-random waitrequest backpressure while idle.
module mem_bus_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [19:0]          address,
  input  logic [1:0]           byteenable,
  input  logic                 read,
  input  logic                 write,
  input  logic [15:0]          writedata,
  output logic [15:0]          readdata,
  output logic                 readdataready,
  output logic                 waitrequest,
  output logic                 protocol_err,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count
);

  localparam int            DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]    LAT_LAST = 4'(READ_LATENCY - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LAT  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              lat_cnt_q, lat_cnt_d;
  logic [15:0]             mem [DEPTH];
  logic [15:0]             rdata_q;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    stall;
  logic                    wr_accept;
  logic                    rd_accept;
  logic                    unused_addr_bits;

  // The array aliases across the full 20-bit space; upper bits are deliberately dropped.
  assign idx              = address[ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^address[19:ADDR_WIDTH];

`ifdef MEM_RESP_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall = (state_q == IDLE) && lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Only registered state and reset feed waitrequest, so it never combinationally depends on the request.
  assign waitrequest = reset
                     || ((state_q == LAT) && (lat_cnt_q < LAT_LAST))
                     || stall;

  // A simultaneous read+write performs the write and drops the read.
  assign wr_accept = write && !waitrequest;
  assign rd_accept = read && !write && !waitrequest;

  // NOTE: every output of this process gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rd_accept) begin
          state_d   = LAT;
          lat_cnt_d = '0;
        end
      end
      LAT: begin
        if (lat_cnt_q == LAT_LAST) begin
          // Response cycle: a new read may be accepted here for back-to-back throughput.
          if (rd_accept) begin
            state_d   = LAT;
            lat_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      rdata_q      <= '0;
      protocol_err <= 1'b0;
      rd_count     <= '0;
      wr_count     <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      if (rd_accept) rdata_q <= mem[idx];
      if (read && write && !waitrequest) protocol_err <= 1'b1;
      if (rd_accept && (rd_count != '1)) rd_count <= rd_count + CNT_WIDTH'(1);
      if (wr_accept && (wr_count != '1)) wr_count <= wr_count + CNT_WIDTH'(1);
    end
  end

  // NOTE: the array has no reset, keeping it mappable to block RAM; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      if (byteenable[0]) mem[idx][7:0]  <= writedata[7:0];
      if (byteenable[1]) mem[idx][15:8] <= writedata[15:8];
    end
  end

  assign readdataready = !reset && (state_q == LAT) && (lat_cnt_q == LAT_LAST);
  assign readdata      = readdataready ? rdata_q : 16'h0000;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed testbench for mem_bus_responder (default parameters, stall feature disabled).
module tb_mem_bus_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] address;
  logic [1:0]  byteenable;
  logic        read;
  logic        write;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        readdataready;
  logic        waitrequest;
  logic        protocol_err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int compared   = 0;
  int mismatched = 0;
  int exp_rd     = 0;
  int exp_wr     = 0;

  mem_bus_responder #(
    .ADDR_WIDTH  (10),
    .READ_LATENCY(2),
    .CNT_WIDTH   (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .byteenable   (byteenable),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .readdataready(readdataready),
    .waitrequest  (waitrequest),
    .protocol_err (protocol_err),
    .rd_count     (rd_count),
    .wr_count     (wr_count)
  );

  always #5 clock = ~clock;

  task automatic do_write(input logic [19:0] a, input logic [1:0] be, input logic [15:0] d);
    int guard = 0;
    @(posedge clock); #1;
    address = a; byteenable = be; writedata = d; write = 1'b1;
    @(negedge clock);
    while (waitrequest && guard < 20) begin @(negedge clock); guard++; end
    @(posedge clock); #1;
    write = 1'b0;
    exp_wr++;
  endtask

  task automatic do_read(input logic [19:0] a, output logic [15:0] d, output int lat);
    int guard = 0;
    @(posedge clock); #1;
    address = a; byteenable = 2'b00; read = 1'b1;
    @(negedge clock);
    while (waitrequest && guard < 20) begin @(negedge clock); guard++; end
    @(posedge clock); #1;
    read = 1'b0;
    exp_rd++;
    lat = 0;
    d   = 16'hxxxx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (readdataready) begin
        lat = i;
        d   = readdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    @(negedge clock);
    compared += 6;
    if (readdata !== 16'h0000) begin mismatched++; $display("FAIL reset_readdata: got %h want 0000", readdata); end
    if (readdataready !== 1'b0) begin mismatched++; $display("FAIL reset_rdy: got %b want 0", readdataready); end
    if (waitrequest !== 1'b1) begin mismatched++; $display("FAIL reset_wait: got %b want 1", waitrequest); end
    if (protocol_err !== 1'b0) begin mismatched++; $display("FAIL reset_perr: got %b want 0", protocol_err); end
    if (rd_count !== 16'd0) begin mismatched++; $display("FAIL reset_rdcnt: got %0d want 0", rd_count); end
    if (wr_count !== 16'd0) begin mismatched++; $display("FAIL reset_wrcnt: got %0d want 0", wr_count); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    compared++;
    if (waitrequest !== 1'b0) begin mismatched++; $display("FAIL post_reset_wait: got %b want 0", waitrequest); end
  endtask

  task automatic test_write_read();
    logic [15:0] d;
    int          lat;
    do_write(20'h00005, 2'b11, 16'hBEEF);
    do_read(20'h00005, d, lat);
    compared += 4;
    if (lat !== 2) begin mismatched++; $display("FAIL wr_rd_latency: got %0d want 2", lat); end
    if (d !== 16'hBEEF) begin mismatched++; $display("FAIL wr_rd_data: got %h want beef", d); end
    if (wr_count !== 16'd1) begin mismatched++; $display("FAIL wr_rd_wrcnt: got %0d want 1", wr_count); end
    if (rd_count !== 16'd1) begin mismatched++; $display("FAIL wr_rd_rdcnt: got %0d want 1", rd_count); end
  endtask

  task automatic test_byte_lanes();
    logic [15:0] d;
    int          lat;
    do_write(20'h00010, 2'b11, 16'h1234);
    do_write(20'h00010, 2'b10, 16'hAB00);
    do_read(20'h00010, d, lat);
    compared++;
    if (d !== 16'hAB34) begin mismatched++; $display("FAIL lane_hi: got %h want ab34", d); end
    do_write(20'h00010, 2'b00, 16'hFFFF);
    do_write(20'h00010, 2'b01, 16'h99CD);
    do_read(20'h00010, d, lat);
    compared += 2;
    if (d !== 16'hABCD) begin mismatched++; $display("FAIL lane_lo_be00: got %h want abcd", d); end
    if (wr_count !== 16'(exp_wr)) begin mismatched++; $display("FAIL lane_wrcnt: got %0d want %0d", wr_count, exp_wr); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    @(posedge clock); #1;
    address = 20'h00005; read = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      compared += 2;
      if (waitrequest !== ((c % 2) == 1)) begin
        mismatched++; $display("FAIL b2b_wait c%0d: got %b want %b", c, waitrequest, (c % 2) == 1);
      end
      if (readdataready !== ((c % 2) == 0 && c >= 2)) begin
        mismatched++; $display("FAIL b2b_rdy c%0d: got %b want %b", c, readdataready, (c % 2) == 0 && c >= 2);
      end
      if (readdataready) begin
        pulses++;
        compared++;
        if (readdata !== 16'hBEEF) begin mismatched++; $display("FAIL b2b_data c%0d: got %h want beef", c, readdata); end
      end
      if (c == 6) begin
        @(posedge clock); #1;
        read = 1'b0;
      end
    end
    exp_rd += 4;
    compared += 2;
    if (pulses !== 4) begin mismatched++; $display("FAIL b2b_pulses: got %0d want 4", pulses); end
    if (rd_count !== 16'(exp_rd)) begin mismatched++; $display("FAIL b2b_rdcnt: got %0d want %0d", rd_count, exp_rd); end
  endtask

  task automatic test_alias();
    logic [15:0] d;
    int          lat;
    do_write(20'h00403, 2'b11, 16'h0F0F);
    do_read(20'h00003, d, lat);
    compared++;
    if (d !== 16'h0F0F) begin mismatched++; $display("FAIL alias: got %h want 0f0f", d); end
  endtask

  task automatic test_protocol();
    logic [15:0] d;
    int          lat;
    @(posedge clock); #1;
    address = 20'h00020; byteenable = 2'b11; writedata = 16'h5555;
    read = 1'b1; write = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
    exp_wr++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      compared++;
      if (readdataready !== 1'b0) begin mismatched++; $display("FAIL perr_no_rdy %0d: got %b want 0", i, readdataready); end
    end
    compared += 3;
    if (protocol_err !== 1'b1) begin mismatched++; $display("FAIL perr_set: got %b want 1", protocol_err); end
    if (rd_count !== 16'(exp_rd)) begin mismatched++; $display("FAIL perr_rdcnt: got %0d want %0d", rd_count, exp_rd); end
    if (wr_count !== 16'(exp_wr)) begin mismatched++; $display("FAIL perr_wrcnt: got %0d want %0d", wr_count, exp_wr); end
    do_read(20'h00020, d, lat);
    compared += 2;
    if (d !== 16'h5555) begin mismatched++; $display("FAIL perr_data: got %h want 5555", d); end
    if (protocol_err !== 1'b1) begin mismatched++; $display("FAIL perr_sticky: got %b want 1", protocol_err); end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] d;
    int          lat;
    @(posedge clock); #1;
    address = 20'h00005; read = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    read = 1'b0; reset = 1'b1;
    @(negedge clock);
    compared += 2;
    if (readdataready !== 1'b0) begin mismatched++; $display("FAIL midrst_rdy_in_reset: got %b want 0", readdataready); end
    if (waitrequest !== 1'b1) begin mismatched++; $display("FAIL midrst_wait_in_reset: got %b want 1", waitrequest); end
    @(posedge clock); #1;
    reset = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      compared++;
      if (readdataready !== 1'b0) begin mismatched++; $display("FAIL midrst_no_rdy %0d: got %b want 0", i, readdataready); end
      if (i == 0) begin
        compared += 5;
        if (waitrequest !== 1'b0) begin mismatched++; $display("FAIL midrst_wait: got %b want 0", waitrequest); end
        if (protocol_err !== 1'b0) begin mismatched++; $display("FAIL midrst_perr: got %b want 0", protocol_err); end
        if (rd_count !== 16'd0) begin mismatched++; $display("FAIL midrst_rdcnt: got %0d want 0", rd_count); end
        if (wr_count !== 16'd0) begin mismatched++; $display("FAIL midrst_wrcnt: got %0d want 0", wr_count); end
        if (readdata !== 16'h0000) begin mismatched++; $display("FAIL midrst_readdata: got %h want 0000", readdata); end
      end
    end
    do_read(20'h00005, d, lat);
    compared += 3;
    if (lat !== 2) begin mismatched++; $display("FAIL midrst_new_lat: got %0d want 2", lat); end
    if (d !== 16'hBEEF) begin mismatched++; $display("FAIL midrst_new_data: got %h want beef", d); end
    if (rd_count !== 16'd1) begin mismatched++; $display("FAIL midrst_new_rdcnt: got %0d want 1", rd_count); end
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    byteenable = 2'b00;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_alias();
    test_protocol();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Synchronous slave (responder) for the tester's 16-bit memory bus: it answers the `address/byteenable/read/write/writedata` requests the tester issues, with `waitrequest` backpressure and a `readdataready` pulse. Requests are served from an internal word array with a fixed, parameterised read latency. The block sits in place of the SRAM arbiter/SRAM pair in simulation and small FPGA builds, so tester traffic can be exercised without external memory.

## Interface
- `ADDR_WIDTH`, 10: internal depth is 2^ADDR_WIDTH words; `address[ADDR_WIDTH-1:0]` indexes the array.
- `READ_LATENCY`, 2: cycles from read acceptance to the `readdataready` pulse; legal range 1..15.
- `CNT_WIDTH`, 16: width of the saturating access counters.

Ports:
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in 20: word address; bits above ADDR_WIDTH-1 ignored, so the array aliases across the space.
- `byteenable` in 2: active-high lane enables; [0]=data[7:0], [1]=data[15:8].
- `read` in 1: read request, held until accepted.
- `write` in 1: write request, held until accepted.
- `writedata` in 16: write data.
- `readdata` out 16: read data, valid only while `readdataready`=1.
- `readdataready` out 1: one-cycle read-response strobe.
- `waitrequest` out 1: request not accepted this cycle.
- `protocol_err` out 1: sticky flag; `read` and `write` were both seen high in an accepting cycle.
- `rd_count` out CNT_WIDTH: count of accepted reads, saturating.
- `wr_count` out CNT_WIDTH: count of accepted writes, saturating.

## Operation
- States:
  - IDLE: no read in flight.
  - LAT: read in flight; latency counter running.
- Accept condition: (`read` | `write`) & !`waitrequest` at a rising edge.
- `waitrequest` is decoded from registered state only, never from the request inputs. It is 1 while `reset`=1, or while in LAT with counter < READ_LATENCY-1.
- Accepted write:
  - For each lane with `byteenable`=1, the array updates from `writedata` at that edge.
  - Lanes with enable 0 are unchanged. `byteenable`=00 changes no data but still counts as a write.
  - `wr_count`+1.
- Accepted read:
  - Array word captured (read-first), counter cleared, IDLE→LAT (or straight to the response for READ_LATENCY=1).
  - `rd_count`+1.
- Read completion:
  - `readdataready`=1 for exactly one cycle, READ_LATENCY cycles after acceptance, carrying the captured word.
  - The state returns to IDLE in that same cycle.
- Read and write high in the same accepting cycle:
  - The write is performed; the read is dropped and not counted.
  - `protocol_err` sets and stays set until reset.
- Only one read is outstanding at a time. `byteenable` is ignored for reads; the full word is returned.
- Counters stick at 2^CNT_WIDTH-1.
- Array contents are not cleared by reset.

## Timing
- Read accepted at edge of cycle T:
  - `readdataready`=1 in cycle T+READ_LATENCY.
  - `waitrequest`=1 in cycles T+1..T+READ_LATENCY-1.
  - `waitrequest`=0 in cycle T+READ_LATENCY, so back-to-back reads are accepted every READ_LATENCY cycles.
- READ_LATENCY=1: `waitrequest` is never raised by reads; one read per cycle, each answered the next cycle.
- Write accepted at edge T: zero-wait; a read of the same address accepted at T+1 returns the new data.
- Read accepted at the same edge as a write to the same address: this cannot happen (see the simultaneous rule above).
- Reset values, held while `reset`=1:
  - `readdata`=0, `readdataready`=0, `waitrequest`=1, `protocol_err`=0, `rd_count`=0, `wr_count`=0, state IDLE.
- Reset mid-read: the in-flight read is discarded, no `readdataready` is issued, and `waitrequest`=0 from the first cycle after `reset` falls.

## Configuration
- `MEM_RESP_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - In IDLE, `waitrequest` is additionally forced to 1 whenever LFSR bit 0 = 1, giving pseudo-random backpressure.
- Undefined: there is no LFSR, and `waitrequest` follows the rules above only.
- Latency and data behaviour are identical in both builds.

## Test plan
- Reset, then write 16'hBEEF to address 20'h00005 with `byteenable`=11, then read 20'h00005 → `readdataready` exactly 2 cycles after acceptance with `readdata`=16'hBEEF; `wr_count`=1, `rd_count`=1.
- Write 16'h1234 (be=11), then 16'hAB00 with be=10 to the same address, then read → 16'hAB34.
- Read held high for 4 consecutive requests with READ_LATENCY=2 → acceptances every 2 cycles, each pulse 1 cycle wide, `waitrequest` high on alternate cycles.
- Write 16'h0F0F to 20'h00403 with ADDR_WIDTH=10, then read 20'h00003 → 16'h0F0F (aliasing).
- `read`=`write`=1 with writedata 16'h5555 → data written, no `readdataready`, `protocol_err`=1 until reset, `rd_count` unchanged.
- Read accepted, then `reset` pulsed for 1 cycle at T+1 → no `readdataready`; all outputs at reset values; a new read accepted right after reset completes normally.
